// File: rtl/alu_seq_pkg.sv
// Shared definitions for the handshaked sequential ALU: control codes,
// FSM state encoding and the iteration-counter width helper.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SRA   = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // The counter must be able to hold WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add unsigned multiply and restoring
// unsigned divide, one step per cycle, WIDTH steps per operation.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    // acc_q holds {hi, lo}: product accumulator / multiplier for multu,
    // partial remainder / dividend-then-quotient for divu.
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;
    logic               active_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH:0]     div_diff;
    logic               div_fit;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_step = acc_q;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_rs - {1'b0, opnd_q};
        div_fit  = (div_rs >= {1'b0, opnd_q});
        if (div_q) begin
            acc_step[WIDTH-1:0]       = {acc_q[WIDTH-2:0], div_fit};
            acc_step[2*WIDTH-1:WIDTH] = div_fit ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start) begin
            acc_q    <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            opnd_q   <= is_div ? b : a;
            div_q    <= is_div;
            active_q <= 1'b1;
            cnt_q    <= CW'(WIDTH);
        end else if (active_q) begin
            if (cnt_q != '0) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q - 1'b1;
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign done = active_q && (cnt_q == '0);
    assign hi   = acc_q[2*WIDTH-1:WIDTH];
    assign lo   = acc_q[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops plus iterative
// multu/divu, with registered result and zero/ovf/dz/illegal flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             ovf,
    output logic             dz,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_t state_q, state_d;

    logic accept, is_iter, start, load_single, load_iter;
    logic it_done;
    logic [WIDTH-1:0] it_hi, it_lo;

    logic [WIDTH-1:0] s_res, sum, diff;
    logic [SHW-1:0]   shamt;
    logic             s_ovf, s_ill;
    logic             dz_pend_q;

    assign in_ready    = !reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept      = in_valid && in_ready;
    assign is_iter     = (control == OP_MULTU) || (control == OP_DIVU);
    assign start       = accept && is_iter;
    assign load_single = accept && !is_iter;
    assign load_iter   = (state_q == BUSY) && it_done;
    assign out_valid   = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = is_iter ? BUSY : DONE;
            BUSY: if (it_done) state_d = DONE;
            DONE: if (out_ready) state_d = !accept ? IDLE : (is_iter ? BUSY : DONE);
            default: state_d = IDLE;
        endcase
    end

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];

    always_comb begin
        s_res = '0;
        s_ovf = 1'b0;
        s_ill = 1'b0;
        unique case (control)
            OP_ADD: begin
                s_res = sum;
                s_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_res = diff;
                s_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  s_res = a & b;
            OP_OR:   s_res = a | b;
            OP_NOR:  s_res = ~(a | b);
            OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: s_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  s_res = a << shamt;
            OP_SRL:  s_res = a >> shamt;
            OP_SRA:  s_res = $unsigned($signed(a) >>> shamt);
            default: s_ill = 1'b1;
        endcase
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .is_div (control == OP_DIVU),
        .a      (a),
        .b      (b),
        .done   (it_done),
        .hi     (it_hi),
        .lo     (it_lo)
    );

    // Illegal codes report zero=0 even though result is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            result    <= '0;
            hi        <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            illegal   <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) dz_pend_q <= (control == OP_DIVU) && (b == '0);
            if (load_single) begin
                result  <= s_res;
                hi      <= '0;
                zero    <= !s_ill && (s_res == '0);
                ovf     <= s_ovf;
                dz      <= 1'b0;
                illegal <= s_ill;
            end else if (load_iter) begin
                result  <= it_lo;
                hi      <= it_hi;
                zero    <= (it_lo == '0);
                ovf     <= 1'b0;
                dz      <= dz_pend_q;
                illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH=32 plus a WIDTH=8 instance.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  control;
    logic [31:0] a, b, result, hi;
    logic        zero, ovf, dz, illegal;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [3:0]  control8;
    logic [7:0]  a8, b8, result8, hi8;
    logic        zero8, ovf8, dz8, illegal8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .zero(zero), .ovf(ovf), .dz(dz), .illegal(illegal)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .control(control8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .hi(hi8), .zero(zero8), .ovf(ovf8), .dz(dz8), .illegal(illegal8)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic        dz;
        logic        ill;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Issue one op with out_ready=1 and wait until out_valid; returns cycles waited.
    task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input string tag, output int lat, output bit ready_seen);
        @(negedge clk);
        control   = c;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, " in_ready at accept"}, in_ready, 1);
        @(negedge clk);
        in_valid   = 1'b0;
        lat        = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int  lat;
        bit  rdy;
        bit  seen;
        bit  iter;

        reset = 1'b1; in_valid = 0; out_ready = 0; control = '0; a = '0; b = '0;
        in_valid8 = 0; out_ready8 = 0; control8 = '0; a8 = '0; b8 = '0;

        vq.push_back('{OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{OP_SUB,   32'd5,        32'd5,        32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_SRA,   32'h80000000, 32'd4,        32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_DIVU,  32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_DIVU,  32'd9,        32'd0,        32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{4'b1111,  32'd5,        32'd3,        32'h0,        32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        vq.push_back('{OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_OR,    32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_NOR,   32'h0,        32'h0,        32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_SLL,   32'h1,        32'h23,       32'h8,        32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_SRL,   32'h80000000, 32'd4,        32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_SUB,   32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{OP_SLT,   32'h1,        32'hFFFFFFFF, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_MULTU, 32'h12345678, 32'h0,        32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{OP_MULTU, 32'h00010000, 32'h00010000, 32'h0,        32'h1, 1'b1, 1'b0, 1'b0, 1'b0});

        // Reset state
        repeat (3) @(negedge clk);
        check("in_ready during reset", in_ready, 0);
        check("out_valid during reset", out_valid, 0);
        reset = 1'b0;
        #1;
        check("in_ready after reset", in_ready, 1);
        check("result after reset", result, 0);
        check("flags after reset", {zero, ovf, dz, illegal, hi}, 0);

        foreach (vq[i]) begin
            string tag;
            tag  = $sformatf("vec%0d ctrl=%b", i, vq[i].ctrl);
            iter = (vq[i].ctrl == OP_MULTU) || (vq[i].ctrl == OP_DIVU);
            issue(vq[i].ctrl, vq[i].a, vq[i].b, tag, lat, rdy);
            check({tag, " latency"}, lat, iter ? 33 : 0);
            if (iter) check({tag, " in_ready low in BUSY"}, rdy, 0);
            check({tag, " out_valid"}, out_valid, 1);
            check({tag, " result"}, result, vq[i].res);
            check({tag, " hi"}, hi, vq[i].hi);
            check({tag, " zero"}, zero, vq[i].zero);
            check({tag, " ovf"}, ovf, vq[i].ovf);
            check({tag, " dz"}, dz, vq[i].dz);
            check({tag, " illegal"}, illegal, vq[i].ill);
        end

        // Back-to-back single-cycle ops with out_ready held high
        @(negedge clk);
        control = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1; out_ready = 1;
        @(negedge clk);
        check("b2b first out_valid", out_valid, 1);
        check("b2b first result", result, 3);
        check("b2b in_ready in DONE", in_ready, 1);
        control = OP_OR; a = 32'd6; b = 32'd1;
        @(negedge clk);
        in_valid = 0;
        check("b2b second out_valid", out_valid, 1);
        check("b2b second result", result, 7);
        @(negedge clk);
        check("b2b drains to idle", out_valid, 0);

        // Backpressure: hold DONE for 5 cycles, other requests ignored
        control = OP_ADD; a = 32'd3; b = 32'd4; in_valid = 1; out_ready = 0;
        @(negedge clk);
        control = OP_SUB; a = 32'd100; b = 32'd1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp out_valid c%0d", k), out_valid, 1);
            check($sformatf("bp result c%0d", k), result, 7);
            check($sformatf("bp in_ready c%0d", k), in_ready, 0);
            @(negedge clk);
        end
        control = OP_SUB; a = 32'd10; b = 32'd4; out_ready = 1;
        #1;
        check("bp in_ready on release", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        check("bp same-cycle accept valid", out_valid, 1);
        check("bp same-cycle accept result", result, 6);
        @(negedge clk);
        check("bp back to idle", out_valid, 0);

        // Reset in the middle of a multiply
        control = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (9) @(negedge clk);
        check("busy in_ready before abort", in_ready, 0);
        reset = 1;
        @(negedge clk);
        check("in_ready while reset", in_ready, 0);
        reset = 0;
        #1;
        check("in_ready after abort", in_ready, 1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1;
            @(negedge clk);
        end
        check("no out_valid after abort", seen, 0);
        check("abort outputs cleared", {result, hi, zero, ovf, dz, illegal}, 0);

        // WIDTH=8 instance
        @(negedge clk);
        control8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01; in_valid8 = 1; out_ready8 = 1;
        @(negedge clk);
        in_valid8 = 0;
        check("w8 add out_valid", out_valid8, 1);
        check("w8 add result", result8, 8'h80);
        check("w8 add ovf", ovf8, 1);
        check("w8 add zero", zero8, 0);
        @(negedge clk);
        control8 = OP_MULTU; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1;
        @(negedge clk);
        in_valid8 = 0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("w8 multu latency", lat, 9);
        check("w8 multu result", result8, 8'h01);
        check("w8 multu hi", hi8, 8'hFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
